// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// mem_wb_stage_pkg : shared bus widths, load-type codes, stall bit indices
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

  localparam int          RegBus      = 32;
  localparam int          RegAddrBus  = 5;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;

  // Load-type codes carried down from the decode stage; 6 and 7 behave as none.
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;

  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
// ============================================================================
// mem_wb_stage_load_align : big-endian byte/halfword select and extension of
// load data; non-load entries pass the ALU result through.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = rdata[DATA_W-1 -: 8];
    case (addr_lo)
      2'd0:    byte_lane = rdata[DATA_W-1  -: 8];
      2'd1:    byte_lane = rdata[DATA_W-9  -: 8];
      2'd2:    byte_lane = rdata[DATA_W-17 -: 8];
      default: byte_lane = rdata[DATA_W-25 -: 8];
    endcase
  end

  assign half_lane = addr_lo[1] ? rdata[DATA_W-17 -: 16] : rdata[DATA_W-1 -: 16];

  always_comb begin
    data = wdata;
    case (ld_type)
      LD_LB:   data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LD_LBU:  data = {{(DATA_W-8){1'b0}}, byte_lane};
      LD_LH:   data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LD_LHU:  data = {{(DATA_W-16){1'b0}}, half_lane};
      LD_LW:   data = rdata;
      default: data = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM/WB pipeline register and register-file write-back port.
// Optional LL/SC link bit when MEM_WB_LLBIT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_ld_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_WB_LLBIT_EN
  input  logic              mem_llbit_we,
  input  logic              mem_llbit_val,
  output logic              llbit_o,
`endif
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
);

  logic [ADDR_W-1:0] v_wd;
  logic              v_wreg;
  logic [DATA_W-1:0] v_wdata;
  logic [2:0]        v_ld_type;
  logic [1:0]        v_addr_lo;
  logic [DATA_W-1:0] v_rdata;

  logic bubble;
  logic capture;
  logic unused_stall_lo;

  assign unused_stall_lo = ^stall[3:0];

  // MEM stalled while WB runs: WB must see an empty slot, not a repeat.
  assign bubble  = flush || (stall[STALL_MEM] && !stall[STALL_WB]);
  assign capture = !stall[STALL_MEM];

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      v_wd      <= '0;
      v_wreg    <= 1'b0;
      v_wdata   <= '0;
      v_ld_type <= LD_NONE;
      v_addr_lo <= 2'b00;
      v_rdata   <= '0;
    end else if (capture) begin
      v_wd      <= mem_wd;
      v_wreg    <= mem_wreg;
      v_wdata   <= mem_wdata;
      v_ld_type <= mem_ld_type;
      v_addr_lo <= mem_addr_lo;
      v_rdata   <= mem_rdata;
    end
  end

  mem_wb_stage_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .ld_type (v_ld_type),
    .addr_lo (v_addr_lo),
    .rdata   (v_rdata),
    .wdata   (v_wdata),
    .data    (wb_wdata)
  );

  assign wb_we    = v_wreg;
  assign wb_waddr = v_wd;

`ifdef MEM_WB_LLBIT_EN
  logic v_llbit_we;
  logic v_llbit_val;
  logic llbit_r;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      v_llbit_we  <= 1'b0;
      v_llbit_val <= 1'b0;
    end else if (capture) begin
      v_llbit_we  <= mem_llbit_we;
      v_llbit_val <= mem_llbit_val;
    end
  end

  // A bubble carries v_llbit_we=0, so only real entries commit the link bit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      llbit_r <= 1'b0;
    end else if (v_llbit_we) begin
      llbit_r <= v_llbit_val;
    end
  end

  assign llbit_o = v_llbit_we ? v_llbit_val : llbit_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : directed self-checking bench for mem_wb_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
`ifdef MEM_WB_LLBIT_EN
  logic        mem_llbit_we;
  logic        mem_llbit_val;
  logic        llbit_o;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_ld_type (mem_ld_type),
    .mem_addr_lo (mem_addr_lo),
    .mem_rdata   (mem_rdata),
`ifdef MEM_WB_LLBIT_EN
    .mem_llbit_we  (mem_llbit_we),
    .mem_llbit_val (mem_llbit_val),
    .llbit_o       (llbit_o),
`endif
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_entry(input logic we, input logic [4:0] wd, input logic [31:0] wdata,
                           input logic [2:0] ld, input logic [1:0] lo, input logic [31:0] rdata);
    mem_wreg    = we;
    mem_wd      = wd;
    mem_wdata   = wdata;
    mem_ld_type = ld;
    mem_addr_lo = lo;
    mem_rdata   = rdata;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    check({tag, ".we"},    {31'd0, wb_we},    {31'd0, we});
    check({tag, ".waddr"}, {27'd0, wb_waddr}, {27'd0, wa});
    check({tag, ".wdata"}, wb_wdata,          wd);
  endtask

  task automatic load_vec(input string tag, input logic [2:0] ld, input logic [1:0] lo, input logic [31:0] exp);
    set_entry(1'b1, 5'd7, 32'hDEAD_BEEF, ld, lo, 32'h80FF_7F01);
    step();
    check(tag, wb_wdata, exp);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 6'b000000;
    flush = 1'b0;
    set_entry(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0);
`ifdef MEM_WB_LLBIT_EN
    mem_llbit_we  = 1'b0;
    mem_llbit_val = 1'b0;
`endif
    @(negedge clk);
    step();
    check_wb("reset_held", 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    step();
    check_wb("after_reset", 1'b0, 5'd0, 32'h0);

    set_entry(1'b1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'hFFFF_FFFF);
    step();
    check_wb("alu_pass", 1'b1, 5'd5, 32'h1234_5678);

    load_vec("lb_0",   3'd1, 2'd0, 32'hFFFF_FF80);
    load_vec("lbu_0",  3'd2, 2'd0, 32'h0000_0080);
    load_vec("lb_2",   3'd1, 2'd2, 32'h0000_007F);
    load_vec("lb_1",   3'd1, 2'd1, 32'hFFFF_FFFF);
    load_vec("lbu_3",  3'd2, 2'd3, 32'h0000_0001);
    load_vec("lh_0",   3'd3, 2'd0, 32'hFFFF_80FF);
    load_vec("lh_1",   3'd3, 2'd1, 32'hFFFF_80FF);
    load_vec("lh_2",   3'd3, 2'd2, 32'h0000_7F01);
    load_vec("lhu_0",  3'd4, 2'd0, 32'h0000_80FF);
    load_vec("lhu_2",  3'd4, 2'd2, 32'h0000_7F01);
    load_vec("lw_3",   3'd5, 2'd3, 32'h80FF_7F01);
    load_vec("rsv_6",  3'd6, 2'd0, 32'hDEAD_BEEF);
    load_vec("rsv_7",  3'd7, 2'd1, 32'hDEAD_BEEF);
    load_vec("none_0", 3'd0, 2'd2, 32'hDEAD_BEEF);

    // MEM stalled, WB running: two bubbles.
    set_entry(1'b1, 5'd9, 32'hAAAA_0001, 3'd0, 2'd0, 32'h0);
    stall = 6'b011111;
    step();
    check_wb("bubble_1", 1'b0, 5'd0, 32'h0);
    step();
    check_wb("bubble_2", 1'b0, 5'd0, 32'h0);

    stall = 6'b000000;
    step();
    check_wb("after_bubble", 1'b1, 5'd9, 32'hAAAA_0001);

    // Both stalled: entry holds while MEM inputs change.
    stall = 6'b111111;
    set_entry(1'b1, 5'd12, 32'hCCCC_0003, 3'd0, 2'd0, 32'h0);
    step();
    check_wb("hold_1", 1'b1, 5'd9, 32'hAAAA_0001);
    step();
    check_wb("hold_2", 1'b1, 5'd9, 32'hAAAA_0001);
    stall = 6'b000000;
    step();
    check_wb("release", 1'b1, 5'd12, 32'hCCCC_0003);

    set_entry(1'b1, 5'd0, 32'h0000_00AB, 3'd0, 2'd0, 32'h0);
    step();
    check_wb("r0_write", 1'b1, 5'd0, 32'h0000_00AB);

    set_entry(1'b1, 5'd3, 32'h3333_3333, 3'd0, 2'd0, 32'h0);
    flush = 1'b1;
    stall = 6'b011111;
    step();
    check_wb("flush_stall", 1'b0, 5'd0, 32'h0);
    stall = 6'b000000;
    step();
    check_wb("flush_only", 1'b0, 5'd0, 32'h0);
    flush = 1'b0;
    step();
    check_wb("post_flush", 1'b1, 5'd3, 32'h3333_3333);

    // Reset during a full stall discards the held entry.
    stall = 6'b111111;
    rst   = 1'b1;
    step();
    check_wb("rst_in_stall", 1'b0, 5'd0, 32'h0);
    rst   = 1'b0;
    stall = 6'b000000;
    set_entry(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0);
    step();

`ifdef MEM_WB_LLBIT_EN
    check("ll_reset", {31'd0, llbit_o}, 32'd0);
    mem_llbit_we  = 1'b1;
    mem_llbit_val = 1'b1;
    step();
    check("ll_fwd", {31'd0, llbit_o}, 32'd1);
    mem_llbit_we  = 1'b0;
    mem_llbit_val = 1'b0;
    step();
    check("ll_reg", {31'd0, llbit_o}, 32'd1);
    step();
    check("ll_keep", {31'd0, llbit_o}, 32'd1);
    set_entry(1'b1, 5'd4, 32'h4444_4444, 3'd0, 2'd0, 32'h0);
    mem_llbit_we  = 1'b1;
    mem_llbit_val = 1'b1;
    flush = 1'b1;
    stall = 6'b011111;
    step();
    check("ll_flush_we", {31'd0, wb_we}, 32'd0);
    check("ll_flush", {31'd0, llbit_o}, 32'd0);
    flush = 1'b0;
    stall = 6'b000000;
    mem_llbit_we = 1'b0;
    step();
    check("ll_after_flush", {31'd0, llbit_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
